// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
// Optional bus-cycle timeout is enabled by defining WBM_TIMEOUT_EN.
package wbm_pkg;

    localparam int WBM_ADDR_W      = 32;
    localparam int WBM_DATA_W      = 32;
    localparam int WBM_TIMEOUT_DEF = 255;

    localparam logic WBM_RSP_OK  = 1'b0;
    localparam logic WBM_RSP_ERR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

    // A zero limit still needs a one-bit counter to elaborate.
    function automatic int wbm_cnt_w(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog: counts stalled BUS cycles and flags expiry.
// Only instantiated when WBM_TIMEOUT_EN is defined.
module wbm_timeout_ctr
    import wbm_pkg::*;
#(
    parameter int LIMIT = WBM_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CW = wbm_cnt_w(LIMIT);
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry fires on the edge that would bring the count up to LIMIT.
    assign expire_o = (LIMIT != 0) && inc_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wbm_initiator.sv
// Wishbone B4 classic single-cycle master behind a valid/ready request port.
// Define WBM_TIMEOUT_EN to abort stalled bus cycles after TIMEOUT_CYC cycles.
module wbm_initiator
    import wbm_pkg::*;
#(
    parameter int ADDR_W      = WBM_ADDR_W,
    parameter int DATA_W      = WBM_DATA_W,
    parameter int TIMEOUT_CYC = WBM_TIMEOUT_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [DATA_W/8-1:0] req_sel_i,
    input  logic [ADDR_W-1:0]   req_adr_i,
    input  logic [DATA_W-1:0]   req_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    wbm_state_e          state_q;
    logic                cyc_q;
    logic                stb_q;
    logic                we_q;
    logic [DATA_W/8-1:0] sel_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   dat_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_dat_q;

    logic                accept_d;
    logic                in_bus_d;
    logic                tmo_expire;
    logic                term_d;
    logic                err_d;
    logic [DATA_W-1:0]   dat_d;

    assign req_ready_o = (state_q == ST_IDLE) && !wb_rst_i;
    assign accept_d    = req_valid_i && req_ready_o;
    assign in_bus_d    = (state_q == ST_BUS);

`ifdef WBM_TIMEOUT_EN
    wbm_timeout_ctr #(
        .LIMIT    (TIMEOUT_CYC)
    ) u_tmo (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clr_i    (accept_d),
        .inc_i    (in_bus_d && !wbm_ack_i && !wbm_err_i),
        .expire_o (tmo_expire)
    );
`else
    // No watchdog: a negative limit is the only value that could ever fire.
    assign tmo_expire = (TIMEOUT_CYC < 0);
`endif

    // Error beats ack; the watchdog only fires when neither is present.
    assign term_d = wbm_err_i || wbm_ack_i || tmo_expire;
    assign err_d  = wbm_err_i || (!wbm_ack_i && tmo_expire);
    assign dat_d  = (err_d || we_q) ? '0 : wbm_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= WBM_RSP_OK;
            rsp_dat_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        sel_q   <= req_sel_i;
                        adr_q   <= req_adr_i;
                        dat_q   <= req_dat_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (in_bus_d && term_d) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_d ? WBM_RSP_ERR : WBM_RSP_OK;
                        rsp_dat_q   <= dat_d;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_wbm_initiator.sv
// Directed bench for wbm_initiator with a response scoreboard.
// Timeout expectations follow WBM_TIMEOUT_EN (limit 4 when defined).
module tb_wbm_initiator;

`ifdef WBM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    wbm_initiator #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_sel_i   (req_sel),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_dat_i   (dat_i),
        .wbm_ack_i   (ack),
        .wbm_err_i   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_we    = w;
        req_adr   = a;
        req_dat   = d;
        req_sel   = s;
    endtask

    task automatic expect_rsp(input string tag);
        int   n;
        rsp_t e;
        n = 0;
        while (!rsp_valid && n < 50) begin
            n++;
            tick();
        end
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_sb"}, 64'(sb_q.size() != 0), 64'd1);
        if (rsp_valid && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
            chk({tag, "_dat"}, 64'(rsp_dat), 64'(e.dat));
        end
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_cyc", 64'(cyc), 64'd0);
        chk("rst_stb", 64'(stb), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_adr", 64'(adr), 64'd0);
        chk("rst_rdat", 64'(rsp_dat), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(req_ready), 64'd1);

        // Ack while idle must not produce a response
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack", 64'(rsp_valid), 64'd0);

        // Write, slave acks after two bus cycles
        send(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF);
        sb_q.push_back('{err: 1'b0, dat: 32'h0});
        tick();
        req_valid = 1'b0;
        chk("wr_cyc", 64'(cyc), 64'd1);
        chk("wr_stb", 64'(stb), 64'd1);
        chk("wr_we", 64'(we), 64'd1);
        chk("wr_adr", 64'(adr), 64'h3000_0004);
        chk("wr_dat", 64'(dat_o), 64'hA5A5_5A5A);
        chk("wr_sel", 64'(sel), 64'hF);
        chk("wr_busy", 64'(req_ready), 64'd0);
        tick();
        chk("wr_wait", 64'(cyc), 64'd1);
        ack   = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        chk("wr_cycdrop", 64'(cyc), 64'd0);
        expect_rsp("wr");
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_rspdone", 64'(rsp_valid), 64'd0);
        chk("wr_ready", 64'(req_ready), 64'd1);

        // Read acked in the first bus cycle
        send(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        sb_q.push_back('{err: 1'b0, dat: 32'h1234_5678});
        tick();
        req_valid = 1'b0;
        chk("rd_we", 64'(we), 64'd0);
        chk("rd_adr", 64'(adr), 64'h3000_0010);
        ack   = 1'b1;
        dat_i = 32'h1234_5678;
        tick();
        ack = 1'b0;
        chk("rd_lat2", 64'(rsp_valid), 64'd1);
        expect_rsp("rd");

        // Backpressure with stray ack/err and a pending request
        send(1'b0, 32'h3000_0020, 32'h0, 4'h3);
        for (int i = 0; i < 5; i++) begin
            ack   = (i == 1);
            err   = (i == 3);
            dat_i = 32'h0BAD_0BAD;
            tick();
            ack = 1'b0;
            err = 1'b0;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_dat", 64'(rsp_dat), 64'h1234_5678);
            chk("bp_err", 64'(rsp_err), 64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_cyc", 64'(cyc), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release", 64'(rsp_valid), 64'd0);
        chk("bp_idle", 64'(req_ready), 64'd1);
        chk("bp_noacc", 64'(cyc), 64'd0);
        sb_q.push_back('{err: 1'b1, dat: 32'h0});
        tick();
        req_valid = 1'b0;
        chk("ep_cyc", 64'(cyc), 64'd1);
        chk("ep_adr", 64'(adr), 64'h3000_0020);
        chk("ep_sel", 64'(sel), 64'h3);

        // Ack and err together: error wins
        ack   = 1'b1;
        err   = 1'b1;
        dat_i = 32'hFFFF_FFFF;
        tick();
        ack = 1'b0;
        err = 1'b0;
        expect_rsp("errprio");
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Slave never acks
        send(1'b0, 32'h3000_0030, 32'h0, 4'hF);
`ifdef WBM_TIMEOUT_EN
        sb_q.push_back('{err: 1'b1, dat: 32'h0});
`else
        sb_q.push_back('{err: 1'b0, dat: 32'hCAFE_F00D});
`endif
        tick();
        req_valid = 1'b0;
        n = 0;
        while (cyc && n < 100) begin
            n++;
            tick();
        end
`ifdef WBM_TIMEOUT_EN
        chk("tmo_cycles", 64'(n), 64'd4);
        expect_rsp("tmo");
`else
        chk("tmo_cycles", 64'(n), 64'd100);
        chk("tmo_still", 64'(cyc), 64'd1);
        ack   = 1'b1;
        dat_i = 32'hCAFE_F00D;
        tick();
        ack = 1'b0;
        expect_rsp("late");
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during a bus wait state
        send(1'b1, 32'h3000_0040, 32'h5555_AAAA, 4'hF);
        tick();
        req_valid = 1'b0;
        chk("mr_cyc", 64'(cyc), 64'd1);
        tick();
        chk("mr_wait", 64'(cyc), 64'd1);
        rst = 1'b1;
        ack = 1'b1;
        tick();
        chk("mr_cyc0", 64'(cyc), 64'd0);
        chk("mr_stb0", 64'(stb), 64'd0);
        chk("mr_rspv", 64'(rsp_valid), 64'd0);
        chk("mr_rdy0", 64'(req_ready), 64'd0);
        rst = 1'b0;
        ack = 1'b0;
        #1;
        chk("mr_rdy1", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_norsp", 64'(rsp_valid), 64'd0);
        end
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
